// File: rtl/lut_sweep_reader.sv
// lut_sweep_reader: reads back a generated neuron LUT by sweeping every input
// code, packing the captured outputs LSB-first into words, and streaming those
// words out on a valid/ready port. Entry a lands in word a/E, slot a%E.
//
// Handshake: a word transfers on any rising edge where m_valid=1 and m_ready=1.
// Once m_valid rises, m_data and m_last hold until that transfer. m_valid never
// depends combinationally on m_ready, and m_ready is ignored while m_valid=0.
module lut_sweep_reader #(
   parameter int IN_BITS     = 8,
   parameter int OUT_BITS    = 2,
   parameter int WORD_BITS   = 32,
   parameter int LUT_LATENCY = 0   // legal range 0..3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic [IN_BITS-1:0]   lut_in,
   input  logic [OUT_BITS-1:0]  lut_out,
   output logic [WORD_BITS-1:0] m_data,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic                 m_last,
   output logic [1:0]           dbg_state
);

   localparam int E   = WORD_BITS / OUT_BITS;        // entries per word
   localparam int W   = (1 << IN_BITS) / E;          // words per sweep
   localparam int SW  = (E > 1) ? $clog2(E) : 1;
   localparam int WCW = (W > 1) ? $clog2(W) : 1;

   localparam logic [SW-1:0]      E_LAST    = SW'(E - 1);
   localparam logic [WCW-1:0]     W_LAST    = WCW'(W - 1);
   localparam logic [1:0]         WAIT_LAST = (LUT_LATENCY > 0) ? 2'(LUT_LATENCY - 1) : 2'd0;
   localparam logic [IN_BITS-1:0] ADDR_ONE  = IN_BITS'(1);
   localparam logic [SW-1:0]      SLOT_ONE  = SW'(1);
   localparam logic [WCW-1:0]     WCNT_ONE  = WCW'(1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_WAIT    = 2'd2,
      S_PRESENT = 2'd3
   } state_t;

   state_t               state;
   logic [IN_BITS-1:0]   addr;      // code currently presented on lut_in
   logic [SW-1:0]        icnt;      // issues done within the current word
   logic [SW-1:0]        slot;      // slot the next capture is written to
   logic [WCW-1:0]       wcnt;      // index of the word being assembled
   logic [1:0]           wait_cnt;
   logic [WORD_BITS-1:0] pack;
   logic                 issuing;
   logic                 cap_v;     // lut_out carries an issued code this cycle

   assign issuing   = (state == S_ISSUE);
   assign lut_in    = addr;
   assign m_data    = pack;
   assign dbg_state = state;

   // Capture qualifier: the issue flag delayed by the LUT's pipeline depth,
   // so only codes this engine actually issued are packed.
   generate
      if (LUT_LATENCY == 0) begin : g_nopipe
         assign cap_v = issuing;
      end else begin : g_pipe
         logic [LUT_LATENCY-1:0] vp;
         // Shift the issue flag down the valid pipeline every cycle.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) vp <= '0;
            else      vp <= (vp << 1) | LUT_LATENCY'(issuing);
         end
         assign cap_v = vp[LUT_LATENCY-1];
      end
   endgenerate

   // Sweep sequencer: issue E codes, let the last capture land, present the
   // packed word, and repeat until all W words have been accepted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         addr     <= '0;
         icnt     <= '0;
         slot     <= '0;
         wcnt     <= '0;
         wait_cnt <= '0;
         pack     <= '0;
         m_valid  <= 1'b0;
         m_last   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (cap_v) begin
            pack[slot*OUT_BITS +: OUT_BITS] <= lut_out;
            slot <= (slot == E_LAST) ? '0 : slot + SLOT_ONE;
         end
         case (state)
            S_IDLE: begin
               // done high means the sweep only just finished; start waits a cycle
               if (start && !done) begin
                  state <= S_ISSUE;
                  busy  <= 1'b1;
                  addr  <= '0;
                  icnt  <= '0;
                  slot  <= '0;
                  wcnt  <= '0;
                  pack  <= '0;
               end
            end
            S_ISSUE: begin
               if (icnt == E_LAST) begin
                  icnt <= '0;
                  if (LUT_LATENCY == 0) begin
                     state   <= S_PRESENT;
                     m_valid <= 1'b1;
                     m_last  <= (wcnt == W_LAST);
                  end else begin
                     state    <= S_WAIT;
                     wait_cnt <= '0;
                  end
               end else begin
                  icnt <= icnt + SLOT_ONE;
                  addr <= addr + ADDR_ONE;
               end
            end
            S_WAIT: begin
               if (wait_cnt == WAIT_LAST) begin
                  state   <= S_PRESENT;
                  m_valid <= 1'b1;
                  m_last  <= (wcnt == W_LAST);
               end else begin
                  wait_cnt <= wait_cnt + 2'd1;
               end
            end
            S_PRESENT: begin
               if (m_ready) begin
                  m_valid <= 1'b0;
                  m_last  <= 1'b0;
                  if (wcnt == W_LAST) begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state <= S_ISSUE;
                     wcnt  <= wcnt + WCNT_ONE;
                     pack  <= '0;
                     addr  <= addr + ADDR_ONE;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
